// File: rtl/dyuv_line_decoder.sv
// dyuv_line_decoder: DYUV byte stream to RGB888 line decoder with a
// delta table, optional U/V interpolation and end-of-line flush.
module dyuv_line_decoder #(
  parameter int MAX_WORDS = 384,
  parameter int FRAC_BITS = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               line_start,
  input  logic [$clog2(MAX_WORDS+1)-1:0]     line_words,
  input  logic [23:0]                        start_yuv,
  input  logic                               interp_en,
  input  logic                               delta_wr,
  input  logic [3:0]                         delta_addr,
  input  logic [7:0]                         delta_data,
  input  logic [7:0]                         in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [23:0]                        out_rgb,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy
);

  localparam int CW = $clog2(MAX_WORDS+1);
  localparam int MW = FRAC_BITS + 12;

  localparam logic signed [MW-1:0] C_RV =
    MW'((351 << FRAC_BITS) >> 8);
  localparam logic signed [MW-1:0] C_GU =
    MW'((86 << FRAC_BITS) >> 8);
  localparam logic signed [MW-1:0] C_GV =
    MW'((179 << FRAC_BITS) >> 8);
  localparam logic signed [MW-1:0] C_BU =
    MW'((444 << FRAC_BITS) >> 8);

  localparam logic [15:0][7:0] DEF_DELTA = {
    8'd255, 8'd252, 8'd247, 8'd240,
    8'd229, 8'd212, 8'd177, 8'd128,
    8'd79,  8'd44,  8'd27,  8'd16,
    8'd9,   8'd4,   8'd1,   8'd0
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_UY,
    S_VY,
    S_FLUSH
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0][7:0] r_delta;
  logic [CW-1:0]    r_len;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_y;
  logic [7:0]       r_y1;
  logic [7:0]       r_u;
  logic [7:0]       r_uprev;
  logic [7:0]       r_v;
  logic             r_interp;
  logic [1:0]       r_fpend;
  logic [23:0]      r_rgb;
  logic             r_valid;
  logic             r_last;

  logic             w_start;
  logic             w_run;
  logic             w_out_free;
  logic             w_acc;
  logic             w_lastbyte;
  logic [7:0]       w_ynew;
  logic [7:0]       w_cnew;
  logic             w_emit;
  logic             w_femit;
  logic             w_plast;
  logic [7:0]       w_py;
  logic [7:0]       w_pu;
  logic [7:0]       w_pv;
  logic [7:0]       w_uavg;
  logic [7:0]       w_vavg;

  function automatic logic [7:0] avg8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8:1];
  endfunction

  // Divide by 2^FRAC_BITS truncating toward zero, then clamp to 0..255.
  function automatic logic [7:0] clamp8(
    input logic signed [MW-1:0] n
  );
    logic signed [MW-1:0] q;
    q = n >>> FRAC_BITS;
    if (n[MW-1] && (n[FRAC_BITS-1:0] != '0))
      q = q + MW'(1);
    if (q[MW-1])
      return 8'd0;
    if (|q[MW-2:8])
      return 8'hFF;
    return q[7:0];
  endfunction

  assign w_start    = line_start && (line_words != '0);
  assign w_run      = (r_state == S_UY) || (r_state == S_VY);
  assign w_out_free = !r_valid || out_ready;
  assign in_ready   = w_run && w_out_free && !w_start;
  assign w_acc      = in_valid && in_ready;
  assign w_lastbyte = (r_cnt == r_len - 1'b1);

  assign w_ynew = r_y + r_delta[in_data[3:0]];
  assign w_cnew = ((r_state == S_UY) ? r_u : r_v)
                + r_delta[in_data[7:4]];

  assign w_uavg = r_interp ? avg8(r_uprev, r_u) : r_uprev;
  assign w_vavg = r_interp ? avg8(r_v, w_cnew) : r_v;

  // Pixel p leaves when byte p+2 arrives; the last two leave in FLUSH.
  always_comb begin
    w_py    = r_y1;
    w_pu    = r_u;
    w_pv    = r_v;
    w_plast = 1'b0;
    w_emit  = 1'b0;
    w_femit = 1'b0;
    unique case (1'b1)
      (w_acc && (r_cnt >= CW'(2))): begin
        w_emit = 1'b1;
        if (r_state == S_VY) begin
          w_pu = w_uavg;
          w_pv = w_vavg;
        end
      end
      ((r_state == S_FLUSH) && (r_fpend == 2'd2)
        && w_out_free): begin
        w_emit  = 1'b1;
        w_femit = 1'b1;
        if (r_len[0])
          w_pu = w_uavg;
      end
      ((r_state == S_FLUSH) && (r_fpend == 2'd1)
        && w_out_free): begin
        w_emit  = 1'b1;
        w_femit = 1'b1;
        w_py    = r_y;
        w_plast = 1'b1;
      end
      default: ;
    endcase
  end

  logic signed [8:0]    w_u9;
  logic signed [8:0]    w_v9;
  logic signed [MW-1:0] w_ys;
  logic signed [MW-1:0] w_us;
  logic signed [MW-1:0] w_vs;
  logic signed [MW-1:0] w_rn;
  logic signed [MW-1:0] w_gn;
  logic signed [MW-1:0] w_bn;
  logic [23:0]          w_rgb;

  assign w_u9 = $signed({1'b0, w_pu}) - 9'sd128;
  assign w_v9 = $signed({1'b0, w_pv}) - 9'sd128;
  assign w_ys = {{(MW-8-FRAC_BITS){1'b0}}, w_py,
                 {FRAC_BITS{1'b0}}};
  assign w_us = {{(MW-9){w_u9[8]}}, w_u9};
  assign w_vs = {{(MW-9){w_v9[8]}}, w_v9};
  assign w_rn = w_ys + C_RV * w_vs;
  assign w_gn = w_ys - C_GU * w_us - C_GV * w_vs;
  assign w_bn = w_ys + C_BU * w_us;
  assign w_rgb = {clamp8(w_rn), clamp8(w_gn), clamp8(w_bn)};

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_UY;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_UY:
          if (w_acc)
            w_state_nxt = w_lastbyte ? S_FLUSH : S_VY;
        S_VY:
          if (w_acc)
            w_state_nxt = w_lastbyte ? S_FLUSH : S_UY;
        S_FLUSH:
          if ((r_fpend == 2'd0) && r_valid
              && out_ready && r_last)
            w_state_nxt = S_IDLE;
        default:
          w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_delta  <= DEF_DELTA;
      r_len    <= '0;
      r_cnt    <= '0;
      r_y      <= '0;
      r_y1     <= '0;
      r_u      <= '0;
      r_uprev  <= '0;
      r_v      <= '0;
      r_interp <= 1'b0;
      r_fpend  <= '0;
      r_rgb    <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (delta_wr)
        r_delta[delta_addr] <= delta_data;

      if (w_start) begin
        r_len    <= line_words;
        r_cnt    <= '0;
        r_y      <= start_yuv[23:16];
        r_y1     <= start_yuv[23:16];
        r_u      <= start_yuv[15:8];
        r_uprev  <= start_yuv[15:8];
        r_v      <= start_yuv[7:0];
        r_interp <= interp_en;
        r_fpend  <= '0;
      end else if (w_acc) begin
        r_cnt <= r_cnt + 1'b1;
        r_y1  <= r_y;
        r_y   <= w_ynew;
        if (r_state == S_UY) begin
          r_uprev <= r_u;
          r_u     <= w_cnew;
        end else begin
          r_v <= w_cnew;
        end
        if (w_lastbyte)
          r_fpend <= (r_len == CW'(1)) ? 2'd1 : 2'd2;
      end else if (w_femit) begin
        r_fpend <= r_fpend - 2'd1;
      end

      if (w_start) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_rgb   <= '0;
      end else if (w_emit) begin
        r_valid <= 1'b1;
        r_last  <= w_plast;
        r_rgb   <= w_rgb;
      end else if (out_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign out_rgb   = r_rgb;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/dyuv_line_decoder.md
Name: dyuv_line_decoder

Overview:
Parametrised DYUV (delta-YUV) line decoder for the video path. It consumes one DYUV byte per pixel from the ICA/DCA pixel fetch and reconstructs Y, U and V from a per-line absolute start colour and a programmable 16-entry delta table. U/V interpolation is selectable, and the block converts to RGB888. It adds ready/valid flow control on both sides, a runtime line length, an end-of-line flush that emits the final two pixels, and an out_last marker. It feeds the mixer/plane compositor.

Parameters:
MAX_WORDS, 384, maximum bytes (= pixels) per line; sets counter width clog2(MAX_WORDS+1).
FRAC_BITS, 8, fixed-point fraction of colour matrix; divide is by 2^FRAC_BITS.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
line_start  in  1  one-cycle pulse; begins a line, samples start_yuv and line_words
line_words  in  clog2(MAX_WORDS+1)  bytes in the coming line (360 ST / 384 normal)
start_yuv  in  24  absolute start {y,u,v}, 8 bits each
interp_en  in  1  1 = linear U/V interpolation, 0 = repeat; sampled at line_start
delta_wr  in  1  write strobe for delta table
delta_addr  in  4  delta table index
delta_data  in  8  delta value
in_data  in  8  DYUV byte: [7:4] U-or-V delta index, [3:0] Y delta index
in_valid  in  1  in_data valid
in_ready  out  1  byte accepted when in_valid && in_ready
out_rgb  out  24  {r,g,b}
out_valid  out  1  out_rgb valid, held until accepted
out_ready  in  1  sink accepts when out_valid && out_ready
out_last  out  1  qualifies last pixel of line
busy  out  1  line in progress (accepting or flushing)

Behaviour:
- Reset (reset=0, async): state IDLE; out_valid=0, out_last=0, out_rgb=0, in_ready=0, busy=0; delta table = {0,1,4,9,16,27,44,79,128,177,212,229,240,247,252,255}.
- States: IDLE -> (line_start && line_words!=0) -> UY. UY <-> VY alternate per accepted byte. Entered after last byte -> FLUSH. FLUSH -> IDLE when the final pixel is accepted. line_start with line_words==0 is ignored.
- Even byte index 2k (UY): Y += delta[lo], U_k = U_(k-1) + delta[hi]. Odd byte 2k+1 (VY): Y += delta[lo], V_k = V_(k-1) + delta[hi]. U_-1, V_-1 and Y are initialised from start_yuv. All additions are mod 256 (wrap, no saturation).
- Pixel p luma = running Y after byte p. Pixel 2k chroma = (U_k, V_k).
- Pixel 2k+1 chroma: with interp_en, floor((U_k+U_(k+1))/2) and the same for V; otherwise (U_k, V_k). If pair k+1 does not exist, (U_k, V_k). If line_words is odd, the last pixel's V = V_(k-1).
- Pixel p is emitted only once byte p+2 has been accepted, or in FLUSH. Pixels leave in order, exactly line_words per line; out_last=1 on pixel line_words-1.
- RGB (signed, at least 20-bit intermediate, division truncates toward zero, then clamp to 0..255):
  - R = (256Y + 351(V-128))/256
  - G = (256Y - 86(U-128) - 179(V-128))/256
  - B = (256Y + 444(U-128))/256
  - Exactly one register stage is allowed after the matrix.
- Flow control: out_valid, out_rgb and out_last stay stable while out_valid && !out_ready. in_ready=0 in IDLE, in FLUSH, or whenever the internal pipeline cannot advance. Zero-bubble throughput: 1 pixel/clk when in_valid=out_ready=1.
- Delta table writes are accepted in any state. A write becomes visible to the first byte accepted on the following cycle or later.
- line_start while busy aborts the line: pending pixels are discarded, out_valid drops next cycle, and the new line starts.
- Reset mid-line clears everything immediately. The delta table returns to its default.

Test Plan:
- start=(128,128,128), line_words=4, bytes 00,00,00,00 -> 4 pixels (128,128,128); out_last only on 4th; busy low after accept.
- start=(16,128,128), line_words=2, bytes 01,01 -> (17,17,17),(18,18,18).
- start=(128,128,128), line_words=4, bytes 00,80,00,80, interp_en=1 -> (0,217,128),(40,172,128),(128,128,128),(128,128,128). Same with interp_en=0 -> 2nd pixel (0,217,128).
- Write delta[1]=10, start y=16, bytes 01,01 -> Y 26,36. Y wrap: start y=250, byte 07 -> Y=(250+79) mod 256=73.
- Random out_ready throttling over a 384-byte line -> output sequence identical to unthrottled run, held stable under stall, exactly 384 pixels.
- Assert reset low at byte 100, or pulse line_start at byte 100 -> out_valid low next cycle; the new line decodes correctly from its start_yuv.
